rr_gen_scheduler: RTL
=====================

Name: rr_gen_scheduler

Overview:
- Round-robin scheduler that shares one generate-replicated resource (one lane per requester, N_REQ lanes built by a generate-for) between N_REQ requesters.
- Sits in front of the lane array and issues a one-hot grant that drives the per-lane enable.
- Grants are held until the owner releases, drops its request, or exceeds a hold budget.
- A one-cycle dead gap follows every release so lane outputs never overlap.

Parameters:
N_REQ, 5, number of requesters/lanes; legal range 2..16.
HOLD_MAX, 8, max cycles a grant may be held before forced release; 0 = unlimited.
IDX_W, $clog2(N_REQ), width of grant index (derived, not overridden).

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
i_req  input  N_REQ  request per requester, level-sensitive.
i_done  input  N_REQ  release strobe per requester; only the bit of the current owner is honoured.
o_gnt  output  N_REQ  one-hot grant, registered; all-zero when idle or in gap.
o_gnt_idx  output  IDX_W  binary index of owner; valid only while o_gnt_valid.
o_gnt_valid  output  1  high while any grant is active (equals |o_gnt).
o_timeout  output  1  one-cycle pulse when a grant is forcibly released by HOLD_MAX.

Behaviour:
- Reset, asynchronous, applies immediately, mid-grant included:
  - o_gnt=0, o_gnt_idx=0, o_gnt_valid=0, o_timeout=0.
  - Priority pointer ptr=0, hold counter=0, state=IDLE.
- State machine: IDLE, GRANT, GAP.
- IDLE:
  - If i_req!=0, pick the first set bit searching ptr, ptr+1, ... N_REQ-1, 0, ... ptr-1.
  - Next edge: state=GRANT, o_gnt=one-hot(pick), o_gnt_idx=pick, counter=1.
  - Latency from sampled request to grant: 1 cycle.
  - If i_req=0, remain in IDLE.
- GRANT:
  - Grant is stable. No preemption by other requests.
  - Release conditions, evaluated each cycle on the owner index k:
    a) i_done[k]=1;
    b) i_req[k]=0;
    c) HOLD_MAX!=0 and counter==HOLD_MAX.
  - On release, next edge:
    - o_gnt=0, state=GAP.
    - ptr=(k+1) mod N_REQ, wrapping N_REQ-1 -> 0.
    - counter=0.
  - o_timeout=1 for exactly that edge only if (c) holds and neither (a) nor (b) holds; done/drop win over timeout.
  - Otherwise counter increments and saturates at HOLD_MAX.
  - i_done bits of non-owners are ignored in all states.
- GAP:
  - Exactly one cycle with o_gnt=0, then IDLE.
  - Arbitration uses the updated ptr, so the same requester can regain the resource only if no other requester is active.
- Width rules:
  - Counter width is $clog2(HOLD_MAX+1), minimum 1.
  - Pointer and index are IDX_W wide; modulo wrap is explicit because N_REQ is not necessarily a power of two.
- Invariants:
  - o_gnt is at most one-hot.
  - o_gnt_valid==|o_gnt.
  - o_gnt never changes while state=GRANT.
  - Minimum spacing between consecutive grants is 2 cycles (release edge + GAP).
- Request-select logic is built by generate-for over N_REQ lanes; no behaviour depends on the lane count except the wrap.

Test Plan:
- Reset, then i_req=5'b00100 -> o_gnt=00100 and o_gnt_idx=2 one cycle later. Pulse i_done[2] -> o_gnt=0 next cycle, one GAP cycle, then IDLE with ptr=3.
- i_req=5'b11111 held, each owner pulses done after 2 cycles -> grant order 0,1,2,3,4,0; each grant lasts 2 cycles followed by one zero cycle. Checks the wrap 4->0.
- HOLD_MAX=8, i_req=5'b00010 held, no done -> o_gnt=00010 for 8 cycles, then o_timeout=1 for one cycle coincident with o_gnt=0. Regrant to 1 after the GAP, since no other requester is active.
- Timeout edge collision: i_done[k] asserted on the same cycle counter==HOLD_MAX -> release occurs and o_timeout stays 0.
- Non-owner done and owner drop: owner 3 granted, i_done[1] pulsed -> no change. i_req[3] deasserted -> release next edge, ptr=4.
- Async reset asserted mid-GRANT, between clock edges -> all outputs 0 immediately. After deassert with i_req=5'b10001 -> grant to index 0, since ptr is reset to 0.

Source files
------------

// File: rtl/rr_gen_scheduler.sv
// ---------------------------------------------------------------------------
// rr_gen_scheduler
//
// Round-robin scheduler that shares one resource, replicated as N_REQ lanes,
// between N_REQ requesters. It issues a registered one-hot grant that drives
// the per-lane enables.
//
// A grant is held until one of these happens:
//   - the owner pulses i_done;
//   - the owner drops its request;
//   - the hold budget HOLD_MAX runs out.
// Every release is followed by one dead cycle with no grant, so the outputs of
// two lanes never overlap.
//
// Parameters:
//   N_REQ     number of requesters/lanes (2..16)
//   HOLD_MAX  maximum cycles a grant may be held, 0 = unlimited
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   i_req        level request per requester
//   i_done       release strobe per requester (only the owner's bit counts)
//   o_gnt        registered one-hot grant, zero when idle or in the gap cycle
//   o_gnt_idx    binary index of the owner, meaningful while o_gnt_valid
//   o_gnt_valid  high while a grant is active (equals |o_gnt)
//   o_timeout    one-cycle pulse when a grant is forcibly released by HOLD_MAX
// ---------------------------------------------------------------------------
module rr_gen_scheduler #(
  parameter int N_REQ    = 5,
  parameter int HOLD_MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           i_req,
  input  logic [N_REQ-1:0]           i_done,
  output logic [N_REQ-1:0]           o_gnt,
  output logic [$clog2(N_REQ)-1:0]   o_gnt_idx,
  output logic                       o_gnt_valid,
  output logic                       o_timeout
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;

  // -------------------------------------------------------------------------
  // Rotating-priority pick, one slice per lane.
  //
  // The search is split into two windows:
  //   - the upper window holds the lanes at or above ptr_q;
  //   - if nothing is requesting there, the pick falls back to the lowest set
  //     bit of the whole request vector.
  // This wraps correctly for any N_REQ without needing a power-of-two modulo.
  // -------------------------------------------------------------------------
  logic [N_REQ-1:0] mask_hi;
  logic [N_REQ-1:0] first_hi;
  logic [N_REQ-1:0] first_all;
  logic [N_REQ:0]   seen_hi;
  logic [N_REQ:0]   seen_all;
  logic [N_REQ-1:0] pick_oh;
  logic [IDX_W-1:0] pick_idx;

  assign seen_hi[0]  = 1'b0;
  assign seen_all[0] = 1'b0;

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign mask_hi[g]    = i_req[g] & (IDX_W'(g) >= ptr_q);
    assign first_hi[g]   = mask_hi[g] & ~seen_hi[g];
    assign seen_hi[g+1]  = seen_hi[g] | mask_hi[g];
    assign first_all[g]  = i_req[g] & ~seen_all[g];
    assign seen_all[g+1] = seen_all[g] | i_req[g];
  end

  assign pick_oh = seen_hi[N_REQ] ? first_hi : first_all;

  // Encode the one-hot pick into a binary lane index.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_oh[i]) begin
        pick_idx = IDX_W'(i);
      end else begin
        pick_idx = pick_idx;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Release conditions, evaluated on the current owner.
  // -------------------------------------------------------------------------
  logic rel_done;
  logic rel_drop;
  logic rel_hold;

  assign rel_done = i_done[idx_q];
  assign rel_drop = ~i_req[idx_q];
  assign rel_hold = (HOLD_MAX != 0) && (cnt_q == CNT_W'(HOLD_MAX));

  // Next-state and next-output computation for the scheduler FSM.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    case (state_q)
      // The gap cycle arbitrates like IDLE. The pointer has already moved
      // past the last owner, so a back-to-back regrant sees just one dead
      // cycle.
      ST_IDLE, ST_GAP: begin
        if (|i_req) begin
          state_d = ST_GRANT;
          gnt_d   = pick_oh;
          idx_d   = pick_idx;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end

      ST_GRANT: begin
        if (rel_done || rel_drop || rel_hold) begin
          state_d   = ST_GAP;
          gnt_d     = '0;
          cnt_d     = '0;
          ptr_d     = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
          // A voluntary release (done or drop) takes precedence over the
          // timeout, so the pulse marks only true forced releases.
          timeout_d = rel_hold & ~rel_done & ~rel_drop;
        end else if (HOLD_MAX != 0 && cnt_q != CNT_W'(HOLD_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase

    valid_d = |gnt_d;
  end

  // State, pointer, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_gnt_idx   = idx_q;
  assign o_gnt_valid = valid_q;
  assign o_timeout   = timeout_q;

endmodule
